// File: rtl/i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// i2c_target_regfile
//
// I2C target that answers a bus master on an open-drain SDA/SCL pair and
// exposes four 16-bit registers selected by a pointer byte, laid out like an
// ADS1115: 0 = conversion (read-only, live conv_data), 1 = config,
// 2 = lo threshold, 3 = hi threshold. Serves as an in-fabric ADC stand-in.
//
// Ports
//   clk_clk        in   system clock, at least 20x the SCL rate
//   reset_reset_n  in   asynchronous active-low reset
//   i2c_scl_in     in   SCL sampled from the pad
//   i2c_sda_in     in   SDA sampled from the pad
//   i2c_sda_oe     out  1 = pull SDA low, 0 = release (never drives high)
//   conv_data      in   live conversion value returned for pointer 0
//   cfg_reg        out  config register
//   lo_thresh      out  lo threshold register
//   hi_thresh      out  hi threshold register
//   wr_strobe      out  one-cycle pulse when a full 16-bit write commits
//   busy           out  high from address match until STOP / repeated START
//
// Build option
//   I2C_TGT_GLITCH_FILTER_EN : when defined, synced SCL and SDA each pass a
//   3-sample majority filter (2 extra clk_clk of latency, pulses of one
//   clk_clk or less are suppressed). Port list is identical either way.
// ---------------------------------------------------------------------------
module i2c_target_regfile #(
    parameter logic [6:0]  DEV_ADDR    = 7'h48,
    parameter logic [15:0] CFG_RST     = 16'h8583,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        i2c_scl_in,
    input  logic        i2c_sda_in,
    output logic        i2c_sda_oe,
    input  logic [15:0] conv_data,
    output logic [15:0] cfg_reg,
    output logic [15:0] lo_thresh,
    output logic [15:0] hi_thresh,
    output logic        wr_strobe,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_MSB, WR_MSB_ACK, WR_LSB,
        WR_LSB_ACK, RD_MSB, RD_MSB_ACK, RD_LSB, RD_LSB_ACK
    } state_t;

    // ---- stage: pad synchronizers ----
    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_s, sda_s;
    logic                   scl_cur, sda_cur;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i2c_scl_in};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i2c_sda_in};
    end

    // Idle bus is high on both lines, so the synchronizers reset to 1.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
        end
    end

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // ---- stage: optional majority filter ----
`ifdef I2C_TGT_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_s};
        sda_hist_d = {sda_hist_q[0], sda_s};
        scl_filt_d = maj3(scl_s, scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_s, sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            scl_hist_q <= '1;
            sda_hist_q <= '1;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_cur = scl_filt_q;
    assign sda_cur = sda_filt_q;
`else
    assign scl_cur = scl_s;
    assign sda_cur = sda_s;
`endif

    // ---- stage: edge / condition detection ----
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    always_comb begin
        scl_prev_d = scl_cur;
        sda_prev_d = sda_cur;
    end

    assign scl_rise  =  scl_cur & ~scl_prev_q;
    assign scl_fall  = ~scl_cur &  scl_prev_q;
    assign start_det =  scl_cur &  scl_prev_q &  sda_prev_q & ~sda_cur;
    assign stop_det  =  scl_cur &  scl_prev_q & ~sda_prev_q &  sda_cur;

    // ---- stage: protocol FSM and register file ----
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        mack_q, mack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        busy_q, busy_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [15:0] cfg_q, cfg_d, lo_q, lo_d, hi_q, hi_d;
    logic [6:0]  shreg_q, shreg_d;
    logic [7:0]  msb_q, msb_d;
    logic [15:0] shadow_q, shadow_d;

    logic [7:0]  rx_byte;
    logic [15:0] sel_reg;
    logic [3:0]  tx_idx;

    assign rx_byte = {shreg_q, sda_cur};
    // Bit index into the shadow word for the bit driven after the current fall.
    assign tx_idx  = {state_q == RD_MSB, 3'd7 - bit_cnt_q};

    always_comb begin
        case (ptr_q)
            2'd0:    sel_reg = conv_data;
            2'd1:    sel_reg = cfg_q;
            2'd2:    sel_reg = lo_q;
            default: sel_reg = hi_q;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        ptr_d       = ptr_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        cfg_d       = cfg_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        shreg_d     = shreg_q;
        msb_d       = msb_q;
        shadow_d    = shadow_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                ADDR, PTR, WR_MSB, WR_LSB: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_d = ADDR_ACK;
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte[0];
                                    end else begin
                                        state_d = IDLE;
                                    end
                                end
                                PTR: begin
                                    ptr_d   = rx_byte[1:0];
                                    state_d = PTR_ACK;
                                end
                                WR_MSB: begin
                                    msb_d   = rx_byte;
                                    state_d = WR_MSB_ACK;
                                end
                                default: begin
                                    state_d = WR_LSB_ACK;
                                    // Pointer 0 is read-only: byte is ACKed, data dropped.
                                    if (ptr_q != 2'd0) begin
                                        wr_strobe_d = 1'b1;
                                        case (ptr_q)
                                            2'd1:    cfg_d = {msb_q, rx_byte};
                                            2'd2:    lo_d  = {msb_q, rx_byte};
                                            default: hi_d  = {msb_q, rx_byte};
                                        endcase
                                    end
                                end
                            endcase
                        end
                    end
                end
                ADDR_ACK, PTR_ACK, WR_MSB_ACK, WR_LSB_ACK: begin
                    // Entered on the 8th rise with SDA released: the first fall
                    // starts the ACK pulse, the second fall ends it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d = 1'b0;
                            case (state_q)
                                ADDR_ACK: begin
                                    if (rw_q) begin
                                        state_d  = RD_MSB;
                                        shadow_d = sel_reg;
                                        sda_oe_d = ~sel_reg[15];
                                    end else begin
                                        state_d = PTR;
                                    end
                                end
                                PTR_ACK:    state_d = WR_MSB;
                                WR_MSB_ACK: state_d = WR_LSB;
                                default:    state_d = WR_MSB;
                            endcase
                        end
                    end
                end
                RD_MSB, RD_LSB: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (scl_fall) begin
                        // Counter wrapped to 0 on the 8th rise: byte is out,
                        // release SDA for the master's ACK bit.
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = (state_q == RD_MSB) ? RD_MSB_ACK : RD_LSB_ACK;
                        end else begin
                            sda_oe_d = ~shadow_q[tx_idx];
                        end
                    end
                end
                RD_MSB_ACK, RD_LSB_ACK: begin
                    if (scl_rise) begin
                        mack_d = ~sda_cur;
                    end else if (scl_fall) begin
                        if (!mack_q) begin
                            state_d = IDLE;
                        end else if (state_q == RD_MSB_ACK) begin
                            state_d  = RD_LSB;
                            sda_oe_d = ~shadow_q[7];
                        end else begin
                            state_d  = RD_MSB;
                            shadow_d = sel_reg;
                            sda_oe_d = ~sel_reg[15];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            ptr_q       <= 2'd0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            cfg_q       <= CFG_RST;
            lo_q        <= 16'h8000;
            hi_q        <= 16'h7FFF;
        end else begin
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            ptr_q       <= ptr_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            cfg_q       <= cfg_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
        end
    end

    // Datapath holding registers carry no reset; they are always loaded
    // before they are used.
    always_ff @(posedge clk_clk) begin
        shreg_q  <= shreg_d;
        msb_q    <= msb_d;
        shadow_q <= shadow_d;
    end

    assign i2c_sda_oe = sda_oe_q;
    assign cfg_reg    = cfg_q;
    assign lo_thresh  = lo_q;
    assign hi_thresh  = hi_q;
    assign wr_strobe  = wr_strobe_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// ---------------------------------------------------------------------------
// tb_i2c_target_regfile
//
// Bit-banged I2C master driving the target through a wired-AND SDA line.
// Register write/readback vectors come from a table; read bytes are checked
// against a queue of expected bytes filled when each read is set up.
// ---------------------------------------------------------------------------
module tb_i2c_target_regfile;

    localparam int Q = 8;   // clk_clk cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m, sda_m;
    logic        sda_oe;
    logic        sda_line;
    logic [15:0] conv_data, cfg_reg, lo_thresh, hi_thresh;
    logic        wr_strobe, busy;

    int tests = 0;
    int fails = 0;
    int strobe_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0]  ptr;
        logic [15:0] wdata;
        logic [15:0] conv;
        logic [15:0] exp_rd;
        int          strobes;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    assign sda_line = sda_m & ~sda_oe;

    always @(posedge clk) if (wr_strobe) strobe_cnt <= strobe_cnt + 1;

    i2c_target_regfile dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .i2c_scl_in    (scl_m),
        .i2c_sda_in    (sda_line),
        .i2c_sda_oe    (sda_oe),
        .conv_data     (conv_data),
        .cfg_reg       (cfg_reg),
        .lo_thresh     (lo_thresh),
        .hi_thresh     (hi_thresh),
        .wr_strobe     (wr_strobe),
        .busy          (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic waitq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_bit(input logic b, input logic glitch, output logic r);
        sda_m = b;
        waitq(Q);
        scl_m = 1'b1;
        if (glitch) begin
            waitq(Q / 2);
            scl_m = 1'b0;
            waitq(1);
            scl_m = 1'b1;
            waitq(Q / 2 - 1);
        end else begin
            waitq(Q);
        end
        r = sda_line;
        waitq(Q);
        scl_m = 1'b0;
        waitq(Q);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; waitq(Q);
        scl_m = 1'b1; waitq(Q);
        sda_m = 1'b0; waitq(Q);
        scl_m = 1'b0; waitq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; waitq(Q);
        scl_m = 1'b1; waitq(Q);
        sda_m = 1'b1; waitq(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], i == glitch_bit, r);
        clk_bit(1'b1, 1'b0, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, 1'b0, r);
            b[i] = r;
        end
        clk_bit(nack, 1'b0, r);
    endtask

    task automatic rd_pop(input logic nack, input string name);
        logic [7:0] b;
        read_byte(nack, b);
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: got 0x%0h, expected nothing queued", name, b);
        end else begin
            chk(name, {24'd0, b}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic wr_word(input logic [7:0] ptr, input logic [15:0] w, output logic [3:0] acks);
        i2c_start();
        write_byte(8'h90, -1, acks[3]);
        write_byte(ptr, -1, acks[2]);
        write_byte(w[15:8], -1, acks[1]);
        write_byte(w[7:0], -1, acks[0]);
        i2c_stop();
    endtask

    task automatic rd_word(input logic [7:0] ptr, input logic [15:0] exp, input string name);
        logic [2:0] acks;
        i2c_start();
        write_byte(8'h90, -1, acks[2]);
        write_byte(ptr, -1, acks[1]);
        i2c_start();
        write_byte(8'h91, -1, acks[0]);
        chk({name, "_acks"}, {29'd0, acks}, 32'h7);
        exp_q.push_back(exp[15:8]);
        exp_q.push_back(exp[7:0]);
        rd_pop(1'b0, {name, "_msb"});
        rd_pop(1'b1, {name, "_lsb"});
        i2c_stop();
    endtask

    function automatic logic [15:0] port_of(input logic [1:0] p);
        case (p)
            2'd1:    return cfg_reg;
            2'd2:    return lo_thresh;
            default: return hi_thresh;
        endcase
    endfunction

    // Hang guard: the whole run needs far fewer cycles than this.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       v;
        logic [3:0] acks;
        logic [2:0] a3;
        logic       ack;
        logic       r;
        int         s0;

        vecs[0] = '{8'h01, 16'h1234, 16'h0000, 16'h1234, 1};
        vecs[1] = '{8'h02, 16'h0F0F, 16'h0000, 16'h0F0F, 1};
        vecs[2] = '{8'h03, 16'hA5C3, 16'h0000, 16'hA5C3, 1};
        vecs[3] = '{8'h00, 16'hFFFF, 16'h5A5A, 16'h5A5A, 0};
        vecs[4] = '{8'hFE, 16'hBEEF, 16'h0000, 16'hBEEF, 1};
        vecs[5] = '{8'h01, 16'h0000, 16'h0000, 16'h0000, 1};

        rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1; conv_data = 16'h0000;
        waitq(5);
        rst_n = 1'b1;
        waitq(5);

        // Reset values
        chk("rst_oe",     {31'd0, sda_oe},    32'd0);
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_strobe", {31'd0, wr_strobe}, 32'd0);
        chk("rst_cfg",    {16'd0, cfg_reg},   32'h8583);
        chk("rst_lo",     {16'd0, lo_thresh}, 32'h8000);
        chk("rst_hi",     {16'd0, hi_thresh}, 32'h7FFF);

        // Partial write: MSB only then STOP
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h90, -1, a3[2]);
        write_byte(8'h03, -1, a3[1]);
        write_byte(8'h55, -1, a3[0]);
        i2c_stop();
        chk("partial_acks",   {29'd0, a3},        32'h7);
        chk("partial_hi",     {16'd0, hi_thresh}, 32'h7FFF);
        chk("partial_strobe", strobe_cnt - s0,    32'd0);

        // Wrong address: no ACK, bus untouched
        i2c_start();
        write_byte(8'h92, -1, ack);
        chk("badaddr_ack",  {31'd0, ack},  32'd0);
        chk("badaddr_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        chk("badaddr_cfg", {16'd0, cfg_reg},   32'h8583);
        chk("badaddr_lo",  {16'd0, lo_thresh}, 32'h8000);

        // Table-driven write then readback
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            conv_data = v.conv;
            s0 = strobe_cnt;
            wr_word(v.ptr, v.wdata, acks);
            chk($sformatf("vec%0d_wacks", i), {28'd0, acks}, 32'hF);
            chk($sformatf("vec%0d_strobe", i), strobe_cnt - s0, v.strobes);
            if (v.ptr[1:0] != 2'd0)
                chk($sformatf("vec%0d_port", i), {16'd0, port_of(v.ptr[1:0])}, {16'd0, v.exp_rd});
            rd_word(v.ptr, v.exp_rd, $sformatf("vec%0d_rd", i));
        end

        // Conversion read: shadow keeps LSB after conv_data changes
        conv_data = 16'hABCD;
        i2c_start();
        write_byte(8'h90, -1, a3[2]);
        write_byte(8'h00, -1, a3[1]);
        i2c_start();
        write_byte(8'h91, -1, a3[0]);
        chk("conv_acks", {29'd0, a3}, 32'h7);
        chk("conv_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        rd_pop(1'b0, "conv_msb");
        conv_data = 16'h0000;
        rd_pop(1'b1, "conv_lsb");
        chk("nack_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        waitq(4);
        chk("stop_busy", {31'd0, busy}, 32'd0);

        // Multi-word write loops on the same pointer
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h90, -1, acks[3]);
        write_byte(8'h02, -1, acks[2]);
        write_byte(8'h11, -1, acks[1]);
        write_byte(8'h11, -1, acks[0]);
        chk("loop_acks1", {28'd0, acks}, 32'hF);
        write_byte(8'h22, -1, acks[1]);
        write_byte(8'h22, -1, acks[0]);
        i2c_stop();
        chk("loop_acks2", {30'd0, acks[1:0]}, 32'h3);
        chk("loop_lo",     {16'd0, lo_thresh}, 32'h2222);
        chk("loop_strobe", strobe_cnt - s0,    32'd2);

        // Sequential read: second word gets a fresh shadow
        conv_data = 16'h1357;
        i2c_start();
        write_byte(8'h90, -1, a3[2]);
        write_byte(8'h00, -1, a3[1]);
        i2c_start();
        write_byte(8'h91, -1, a3[0]);
        chk("seq_acks", {29'd0, a3}, 32'h7);
        exp_q.push_back(8'h13);
        exp_q.push_back(8'h57);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h68);
        rd_pop(1'b0, "seq_b0");
        conv_data = 16'h2468;
        rd_pop(1'b0, "seq_b1");
        rd_pop(1'b0, "seq_b2");
        rd_pop(1'b1, "seq_b3");
        i2c_stop();

`ifdef I2C_TGT_GLITCH_FILTER_EN
        // One-clock SCL low pulse mid-byte must not disturb reception
        i2c_start();
        write_byte(8'h90, -1, acks[3]);
        write_byte(8'h01, -1, acks[2]);
        write_byte(8'hC3, 3, acks[1]);
        write_byte(8'h3C, -1, acks[0]);
        i2c_stop();
        chk("glitch_acks", {28'd0, acks}, 32'hF);
        chk("glitch_cfg",  {16'd0, cfg_reg}, 32'hC33C);
`endif

        // Reset while the target is pulling SDA low mid read
        conv_data = 16'h0000;
        i2c_start();
        write_byte(8'h90, -1, a3[2]);
        write_byte(8'h00, -1, a3[1]);
        i2c_start();
        write_byte(8'h91, -1, a3[0]);
        for (int i = 0; i < 4; i++) clk_bit(1'b1, 1'b0, r);
        chk("prerst_oe", {31'd0, sda_oe}, 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_oe_async", {31'd0, sda_oe}, 32'd0);
        waitq(1);
        chk("midrst_oe",   {31'd0, sda_oe},    32'd0);
        chk("midrst_busy", {31'd0, busy},      32'd0);
        chk("midrst_cfg",  {16'd0, cfg_reg},   32'h8583);
        chk("midrst_lo",   {16'd0, lo_thresh}, 32'h8000);
        chk("midrst_hi",   {16'd0, hi_thresh}, 32'h7FFF);
        waitq(3);
        rst_n = 1'b1;
        waitq(3);
        i2c_stop();

        // Pointer is back to 0 after reset: plain read returns conv_data
        conv_data = 16'h4321;
        i2c_start();
        write_byte(8'h91, -1, ack);
        chk("postrst_ack", {31'd0, ack}, 32'd1);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h21);
        rd_pop(1'b0, "postrst_msb");
        rd_pop(1'b1, "postrst_lsb");
        i2c_stop();

        waitq(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
